lcd_bus_controller: RTL and testbench



---
 rtl/lcd_bus_controller_if.sv | 33 +++
 rtl/lcd_bus_controller.sv | 203 ++++++++++++++++++++
 tb/tb_lcd_bus_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_controller_if.sv
// ----------------------------------------------------------------------------
// lcd_bus_controller_if
// Bundles the generator-side handshake (DATA_IN/ENB/RDY/INIT_DONE) and the
// LCD pin group (LCD_RS/LCD_RW/LCD_E/LCD_DB) of the LCD bus controller.
//   DATA_IN[9:0] : {RS, RW, DB[7:0]} word offered by the message generator
//   ENB          : write strobe, only honoured while RDY=1
//   RDY          : controller can accept a word this cycle
//   INIT_DONE    : power-on init sequence complete (sticky)
//   LCD_RS/RW/E/DB : character LCD pins
// Modports:
//   master : message generator (drives the word and strobe, observes the rest)
//   slave  : the controller itself
// ----------------------------------------------------------------------------
interface lcd_bus_controller_if;
    logic [9:0] DATA_IN;
    logic       ENB;
    logic       RDY;
    logic       INIT_DONE;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_E;
    logic [7:0] LCD_DB;

    modport master (
        output DATA_IN, ENB,
        input  RDY, INIT_DONE, LCD_RS, LCD_RW, LCD_E, LCD_DB
    );

    modport slave (
        input  DATA_IN, ENB,
        output RDY, INIT_DONE, LCD_RS, LCD_RW, LCD_E, LCD_DB
    );
endinterface

// File: rtl/lcd_bus_controller.sv
// ----------------------------------------------------------------------------
// lcd_bus_controller
// Sequences an HD44780-style character LCD: runs the power-on init list, then
// accepts {RS,RW,DB} words from a generator over the RDY/ENB handshake and
// drives the LCD pins with setup, E-pulse and execution-wait timing.
// Clock is expected at 1 MHz, so every *_CYC parameter is in microseconds.
// Ports:
//   CLK : system clock, rising edge
//   RST : synchronous, active-high reset (restarts the whole init sequence)
//   bus : lcd_bus_controller_if.slave (handshake + LCD pins)
// ----------------------------------------------------------------------------
module lcd_bus_controller #(
    parameter int POWERUP_CYC    = 15000,
    parameter int INIT_WAIT1_CYC = 4100,
    parameter int INIT_WAIT2_CYC = 100,
    parameter int CMD_WAIT_CYC   = 40,
    parameter int CLEAR_WAIT_CYC = 1640,
    parameter int SETUP_CYC      = 1,
    parameter int E_HIGH_CYC     = 1
) (
    input  logic               CLK,
    input  logic               RST,
    lcd_bus_controller_if.slave bus
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max_of(max_of(max_of(POWERUP_CYC, INIT_WAIT1_CYC),
                                           max_of(INIT_WAIT2_CYC, CMD_WAIT_CYC)),
                                    max_of(max_of(CLEAR_WAIT_CYC, SETUP_CYC),
                                           E_HIGH_CYC));
    localparam int CNT_W = $clog2(MAX_CYC) + 1;

    // SETUP holds one extra cycle: the word is latched onto RS/DB on entry,
    // and the following SETUP_CYC cycles give the LCD its address setup time
    // with the bus already settled.
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC + 1);
    localparam logic [CNT_W-1:0] E_LOAD     = CNT_W'(E_HIGH_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       LAST_IDX   = 4'd7;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_SETUP,
        ST_PULSE,
        ST_WAIT,
        ST_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             init_done_q, init_done_d;
    logic             rdy_q, rdy_d;
    logic             rs_q, rs_d;
    logic [7:0]       db_q, db_d;
    logic             e_q, e_d;
    logic [CNT_W-1:0] wait_sel;

    // The RW bit of the incoming word is deliberately dropped: the LCD is
    // only ever written.
    logic unused_rw;
    assign unused_rw = bus.DATA_IN[8];

    function automatic logic [7:0] init_word(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd2: init_word = 8'h30;   // function set, 8-bit, x3
            4'd3:             init_word = 8'h38;   // 8-bit, 2 lines, 5x8
            4'd4:             init_word = 8'h08;   // display off
            4'd5:             init_word = 8'h01;   // clear
            4'd6:             init_word = 8'h06;   // entry mode: increment
            default:          init_word = 8'h0C;   // display on, cursor off
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] init_wait(input logic [3:0] idx);
        case (idx)
            4'd0:    init_wait = CNT_W'(INIT_WAIT1_CYC);
            4'd1:    init_wait = CNT_W'(INIT_WAIT2_CYC);
            4'd5:    init_wait = CNT_W'(CLEAR_WAIT_CYC);
            default: init_wait = CNT_W'(CMD_WAIT_CYC);
        endcase
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) are the slow commands.
    always_comb begin
        wait_sel = CNT_W'(CMD_WAIT_CYC);
        if (!init_done_q) begin
            wait_sel = init_wait(idx_q);
        end else if (!rs_q && (db_q[7:2] == 6'd0)) begin
            wait_sel = CNT_W'(CLEAR_WAIT_CYC);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        rs_d        = rs_q;
        db_d        = db_q;

        case (state_q)
            ST_PWRUP: begin
                // Reset leaves the counter at 0; that first cycle counts as
                // the first power-up cycle and loads the remainder.
                if ((cnt_q == CNT_ONE) || ((cnt_q == '0) && (POWERUP_CYC <= 1))) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                    idx_d   = 4'd0;
                    rs_d    = 1'b0;
                    db_d    = init_word(4'd0);
                end else if (cnt_q == '0) begin
                    cnt_d = CNT_W'(POWERUP_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_PULSE;
                    cnt_d   = E_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_WAIT;
                    cnt_d   = wait_sel;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    if (init_done_q) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == LAST_IDX) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LOAD;
                        idx_d   = idx_q + 4'd1;
                        db_d    = init_word(idx_q + 4'd1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_IDLE: begin
                // RS/DB hold their last value here so the bus never twitches.
                if (bus.ENB) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                    rs_d    = bus.DATA_IN[9];
                    db_d    = bus.DATA_IN[7:0];
                end
            end
            default: begin
                state_d = ST_PWRUP;
                cnt_d   = '0;
            end
        endcase

        // Outputs registered from the next state so they line up with state_q.
        rdy_d = (state_d == ST_IDLE);
        e_d   = (state_d == ST_PULSE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_PWRUP;
            cnt_q       <= '0;
            idx_q       <= 4'd0;
            init_done_q <= 1'b0;
            rdy_q       <= 1'b0;
            rs_q        <= 1'b0;
            db_q        <= 8'h00;
            e_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            rdy_q       <= rdy_d;
            rs_q        <= rs_d;
            db_q        <= db_d;
            e_q         <= e_d;
        end
    end

    assign bus.RDY       = rdy_q;
    assign bus.INIT_DONE = init_done_q;
    assign bus.LCD_RS    = rs_q;
    assign bus.LCD_RW    = 1'b0;
    assign bus.LCD_E     = e_q;
    assign bus.LCD_DB    = db_q;

endmodule

// File: tb/tb_lcd_bus_controller.sv
// ----------------------------------------------------------------------------
// tb_lcd_bus_controller
// Directed bench for lcd_bus_controller with shortened timing parameters
// (POWERUP=20, WAIT1=10, WAIT2=5, CMD=4, CLEAR=12, SETUP=1, E_HIGH=2).
// Cycle numbers below count rising edges after the reference edge.
// ----------------------------------------------------------------------------
module tb_lcd_bus_controller;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    lcd_bus_controller_if bus();

    lcd_bus_controller #(
        .POWERUP_CYC    (20),
        .INIT_WAIT1_CYC (10),
        .INIT_WAIT2_CYC (5),
        .CMD_WAIT_CYC   (4),
        .CLEAR_WAIT_CYC (12),
        .SETUP_CYC      (1),
        .E_HIGH_CYC     (2)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Init list and the edge (after the last reset edge) at which each E
    // pulse starts: 20 power-up, then per word 2 setup + 2 high + wait.
    logic [7:0] exp_db   [8];
    int         exp_rise [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Follows a full init sequence starting right after the last reset edge.
    task automatic watch_init(input string tag);
        int  rises;
        int  rise_t;
        bit  prev_e;
        bit  done_seen;
        rises     = 0;
        rise_t    = 0;
        prev_e    = 1'b0;
        done_seen = 1'b0;
        for (int t = 1; t <= 200 && !done_seen; t++) begin
            tick();
            if (bus.LCD_E && !prev_e) begin
                if (rises < 8) begin
                    check({tag, "_rise_time"}, t, exp_rise[rises]);
                    check({tag, "_db"}, bus.LCD_DB, exp_db[rises]);
                    check({tag, "_rs"}, bus.LCD_RS, 1'b0);
                end
                rises++;
                rise_t = t;
            end
            if (!bus.LCD_E && prev_e) begin
                check({tag, "_e_width"}, t - rise_t, 2);
            end
            if (bus.RDY !== bus.INIT_DONE) begin
                check({tag, "_rdy_with_done"}, bus.RDY, bus.INIT_DONE);
            end
            if (bus.INIT_DONE) begin
                done_seen = 1'b1;
                check({tag, "_done_time"}, t, 99);
                check({tag, "_done_rdy"}, bus.RDY, 1'b1);
            end
            prev_e = bus.LCD_E;
        end
        check({tag, "_done_seen"}, done_seen, 1'b1);
        check({tag, "_pulse_count"}, rises, 8);
        $display("init %s: %0d E pulses, init_done=%0b", tag, rises, bus.INIT_DONE);
    endtask

    // One user write, issued in the current RDY cycle.
    task automatic do_write(input string tag, input logic [9:0] word, input int exp_ready);
        int  rises;
        int  rise_t;
        bit  prev_e;
        bit  done;
        int  ready_t;
        bus.DATA_IN = word;
        bus.ENB     = 1'b1;
        tick();
        bus.ENB     = 1'b0;
        check({tag, "_rdy_drop"}, bus.RDY, 1'b0);
        check({tag, "_rs"}, bus.LCD_RS, word[9]);
        check({tag, "_db"}, bus.LCD_DB, word[7:0]);
        check({tag, "_rw"}, bus.LCD_RW, 1'b0);
        check({tag, "_e_low"}, bus.LCD_E, 1'b0);
        rises   = 0;
        rise_t  = 0;
        prev_e  = 1'b0;
        done    = 1'b0;
        ready_t = 0;
        for (int n = 1; n <= 40 && !done; n++) begin
            tick();
            if (bus.LCD_E && !prev_e) begin
                rises++;
                rise_t = n;
                check({tag, "_e_rise_time"}, n, 2);
                check({tag, "_db_at_e"}, bus.LCD_DB, word[7:0]);
            end
            if (!bus.LCD_E && prev_e) begin
                check({tag, "_e_width"}, n - rise_t, 2);
            end
            if (bus.RDY) begin
                done    = 1'b1;
                ready_t = n;
                check({tag, "_ready_time"}, n, exp_ready);
            end
            prev_e = bus.LCD_E;
        end
        check({tag, "_ready_seen"}, done, 1'b1);
        check({tag, "_pulse_count"}, rises, 1);
        $display("write %s data=%03h rs=%0b db=%02h ready_after=%0d", tag, word,
                 bus.LCD_RS, bus.LCD_DB, ready_t);
    endtask

    initial begin
        int held_rises;
        int held_rw_high;
        bit pe;

        exp_db   = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        exp_rise = '{22, 36, 45, 53, 61, 69, 85, 93};
        n_cmp = 0;
        n_err = 0;
        clk   = 1'b0;
        rst   = 1'b1;
        bus.ENB     = 1'b0;
        bus.DATA_IN = 10'h000;

        // Reset state
        repeat (3) tick();
        check("rst_rdy", bus.RDY, 1'b0);
        check("rst_init_done", bus.INIT_DONE, 1'b0);
        check("rst_rs", bus.LCD_RS, 1'b0);
        check("rst_rw", bus.LCD_RW, 1'b0);
        check("rst_e", bus.LCD_E, 1'b0);
        check("rst_db", bus.LCD_DB, 8'h00);
        $display("reset: rdy=%0b init_done=%0b e=%0b db=%02h", bus.RDY, bus.INIT_DONE,
                 bus.LCD_E, bus.LCD_DB);
        rst = 1'b0;

        // Power-on init with ENB idle
        watch_init("init0");

        // User writes, back to back from the first RDY cycle
        do_write("char_H", 10'b10_0100_1000, 8);
        do_write("clear", 10'b00_0000_0001, 16);
        do_write("ddram80", 10'b00_1000_0000, 8);
        do_write("rw_ignored", 10'b11_0100_0001, 8);

        // ENB held high for 40 cycles: one capture per 9-edge round trip
        held_rises   = 0;
        held_rw_high = 0;
        pe           = 1'b0;
        bus.DATA_IN  = 10'h0C0;
        bus.ENB      = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i == 40) bus.ENB = 1'b0;
            tick();
            if (bus.LCD_E && !pe) held_rises++;
            if (bus.LCD_RW) held_rw_high++;
            pe = bus.LCD_E;
        end
        check("held_pulse_count", held_rises, 5);
        check("held_rw_high_cycles", held_rw_high, 0);
        check("held_final_rdy", bus.RDY, 1'b1);
        check("held_final_db", bus.LCD_DB, 8'hC0);
        $display("held ENB: %0d writes in 40 cycles", held_rises);

        // Reset while E is high in the middle of a user write
        bus.DATA_IN = 10'b10_0100_1000;
        bus.ENB     = 1'b1;
        tick();
        bus.ENB     = 1'b0;
        tick();
        tick();
        check("midrst_pre_e", bus.LCD_E, 1'b1);
        rst = 1'b1;
        tick();
        check("midrst_e", bus.LCD_E, 1'b0);
        check("midrst_rdy", bus.RDY, 1'b0);
        check("midrst_init_done", bus.INIT_DONE, 1'b0);
        check("midrst_db", bus.LCD_DB, 8'h00);
        check("midrst_rs", bus.LCD_RS, 1'b0);
        $display("mid-write reset: e=%0b rdy=%0b init_done=%0b db=%02h", bus.LCD_E,
                 bus.RDY, bus.INIT_DONE, bus.LCD_DB);
        rst = 1'b0;

        // Replayed init with ENB asserted throughout: must be ignored
        bus.DATA_IN = 10'h3FF;
        bus.ENB     = 1'b1;
        watch_init("init1_enb");
        bus.ENB = 1'b0;
        tick();
        check("post_init_rdy", bus.RDY, 1'b1);
        check("post_init_e", bus.LCD_E, 1'b0);
        check("post_init_db", bus.LCD_DB, 8'h0C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
